// File: rtl/vga_mem_arbiter_if.sv
// Bus bundle between the VGA fetch logic / CPU bus (master side) and the
// video RAM arbiter (slave side), including the arbiter's RAM port.
interface vga_mem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_valid;
    logic [DATA_W-1:0] disp_data;

    logic              cpu_access;
    logic              cpu_wr_en;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wr_en;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  disp_req, disp_addr,
        output disp_valid, disp_data,
        input  cpu_access, cpu_wr_en, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        output ram_addr, ram_wr_en, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output disp_req, disp_addr,
        input  disp_valid, disp_data,
        output cpu_access, cpu_wr_en, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        input  ram_addr, ram_wr_en, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/vga_mem_arbiter.sv
// Single-port video RAM arbiter: display fetches own the port with fixed
// 3-cycle latency, the CPU gets any slot the display leaves free.
module vga_mem_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    vga_mem_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAM  = 2'd1,
        ST_DATA = 2'd2,
        ST_ACK  = 2'd3
    } cpu_state_t;

    cpu_state_t        r_state;
    logic              r_cpu_wr;
    logic              r_cpu_ack;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_ram_wr_en;
    logic [DATA_W-1:0] r_ram_wdata;

    logic              r_disp_p1;
    logic              r_disp_p2;
    logic              r_disp_valid;
    logic [DATA_W-1:0] r_disp_data;

    // CPU FSM and RAM port issue; a CPU slot is only taken when disp_req is low,
    // so the two address loads below are mutually exclusive.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_cpu_wr    <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_cpu_rdata <= {DATA_W{1'b0}};
            r_ram_addr  <= {ADDR_W{1'b0}};
            r_ram_wr_en <= 1'b0;
            r_ram_wdata <= {DATA_W{1'b0}};
        end else begin
            r_ram_wr_en <= 1'b0;
            if (bus.disp_req) begin
                r_ram_addr <= bus.disp_addr;
            end
            case (r_state)
                ST_IDLE: begin
                    r_cpu_ack <= 1'b0;
                    if (bus.cpu_access && !bus.disp_req) begin
                        r_state     <= ST_RAM;
                        r_cpu_wr    <= bus.cpu_wr_en;
                        r_ram_addr  <= bus.cpu_addr;
                        r_ram_wr_en <= bus.cpu_wr_en;
                        r_ram_wdata <= bus.cpu_wdata;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RAM: begin
                    r_cpu_ack <= 1'b0;
                    r_state   <= ST_DATA;
                end
                ST_DATA: begin
                    r_cpu_ack   <= 1'b1;
                    r_cpu_rdata <= r_cpu_wr ? {DATA_W{1'b0}} : bus.ram_rdata;
                    r_state     <= ST_ACK;
                end
                ST_ACK: begin
                    r_cpu_ack <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_cpu_ack <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    // Display return pipeline: request, RAM address, RAM data, then valid.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_disp_p1    <= 1'b0;
            r_disp_p2    <= 1'b0;
            r_disp_valid <= 1'b0;
            r_disp_data  <= {DATA_W{1'b0}};
        end else begin
            r_disp_p1    <= bus.disp_req;
            r_disp_p2    <= r_disp_p1;
            r_disp_valid <= r_disp_p2;
            if (r_disp_p2) begin
                r_disp_data <= bus.ram_rdata;
            end
        end
    end

    assign bus.disp_valid = r_disp_valid;
    assign bus.disp_data  = r_disp_data;
    assign bus.cpu_ack    = r_cpu_ack;
    assign bus.cpu_rdata  = r_cpu_rdata;
    assign bus.ram_addr   = r_ram_addr;
    assign bus.ram_wr_en  = r_ram_wr_en;
    assign bus.ram_wdata  = r_ram_wdata;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Self-checking bench for vga_mem_arbiter: directed scenarios plus random
// traffic, checked every cycle against a cycle-indexed behavioural model.
module tb_vga_mem_arbiter;
    localparam int AW = 12;
    localparam int DW = 16;
    localparam int M  = 16;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    vga_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    vga_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk    (clk),
        .i_reset_n(reset_n),
        .bus      (bus)
    );

    logic [DW-1:0] ram  [0:4095];
    logic [DW-1:0] mmem [0:4095];

    // Synchronous RAM: data for the presented address appears next cycle.
    always @(posedge clk) begin
        if (bus.ram_wr_en === 1'b1) ram[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= ram[bus.ram_addr];
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_on = 1'b0;

    // Expected outputs, indexed by cycle modulo M.
    bit            e_dv  [M];
    logic [DW-1:0] e_dd  [M];
    bit            e_ack [M];
    logic [DW-1:0] e_rd  [M];
    bit            e_wr  [M];
    logic [AW-1:0] e_addr[M];
    logic [DW-1:0] e_wd  [M];
    int            e_own [M];   // 0 none, 1 display read, 2 cpu read, 3 cpu write
    int            cpu_free_at = 0;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;
    req_t q[$];
    bit   m_active  = 1'b0;
    int   m_ack_cyc = -10;
    bit   prev_rst  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Advance the model by one cycle given this cycle's inputs.
    task automatic model_step(input bit rst_v);
        int c;
        int i0, i1, i2, i3, i4;
        c  = cyc;
        i0 = c % M; i1 = (c + 1) % M; i2 = (c + 2) % M; i3 = (c + 3) % M; i4 = (c + 4) % M;
        e_dv[i4] = 1'b0; e_ack[i4] = 1'b0;
        case (e_own[i0])
            1: begin e_dv[i2] = 1'b1; e_dd[i2] = mmem[e_addr[i0]]; end
            2: e_rd[i2] = mmem[e_addr[i0]];
            3: begin mmem[e_addr[i0]] = e_wd[i0]; e_rd[i2] = '0; end
            default: ;
        endcase
        if (!rst_v) begin
            for (int k = 1; k <= 3; k++) begin
                e_dv[(c + k) % M]  = 1'b0;
                e_ack[(c + k) % M] = 1'b0;
            end
            e_own[i1] = 0; e_wr[i1] = 1'b0; e_addr[i1] = '0; e_wd[i1] = '0;
            cpu_free_at = c + 1;
        end else if (bus.disp_req) begin
            e_own[i1] = 1; e_wr[i1] = 1'b0; e_addr[i1] = bus.disp_addr; e_wd[i1] = e_wd[i0];
        end else if (bus.cpu_access && c >= cpu_free_at) begin
            e_own[i1]  = bus.cpu_wr_en ? 3 : 2;
            e_wr[i1]   = bus.cpu_wr_en;
            e_addr[i1] = bus.cpu_addr;
            e_wd[i1]   = bus.cpu_wdata;
            e_ack[i3]  = 1'b1;
            m_ack_cyc  = c + 3;
            cpu_free_at = c + 4;
        end else begin
            e_own[i1] = 0; e_wr[i1] = 1'b0; e_addr[i1] = e_addr[i0]; e_wd[i1] = e_wd[i0];
        end
    endtask

    // One clock cycle: drive display/reset inputs, run the CPU master, update the model.
    task automatic tick(input bit rst_v, input bit dreq_v, input logic [AW-1:0] daddr_v);
        req_t r;
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        reset_n       = rst_v;
        bus.disp_req  = dreq_v;
        bus.disp_addr = daddr_v;
        if (prev_rst && rst_v) begin
            m_active  = 1'b0;
            m_ack_cyc = cyc - 1;
        end else if (m_active && cyc == m_ack_cyc + 1) begin
            m_active = 1'b0;
        end
        if (!m_active && q.size() > 0 && cyc >= m_ack_cyc + 2) begin
            r = q.pop_front();
            m_active      = 1'b1;
            bus.cpu_wr_en = r.wr;
            bus.cpu_addr  = r.addr;
            bus.cpu_wdata = r.data;
        end
        bus.cpu_access = m_active;
        prev_rst = !rst_v;
        model_step(rst_v);
    endtask

    int ci;
    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            ci = cyc % M;
            chk("ram_wr_en", 32'(bus.ram_wr_en), 32'(e_wr[ci]));
            chk("ram_addr", 32'(bus.ram_addr), 32'(e_addr[ci]));
            chk("ram_wdata", 32'(bus.ram_wdata), 32'(e_wd[ci]));
            chk("disp_valid", 32'(bus.disp_valid), 32'(e_dv[ci]));
            if (e_dv[ci]) chk("disp_data", 32'(bus.disp_data), 32'(e_dd[ci]));
            chk("cpu_ack", 32'(bus.cpu_ack), 32'(e_ack[ci]));
            if (e_ack[ci]) chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(e_rd[ci]));
        end
    end

    logic [DW-1:0] v;
    bit            d;
    initial begin
        reset_n = 1'b0;
        bus.disp_req = 1'b0; bus.disp_addr = '0;
        bus.cpu_access = 1'b0; bus.cpu_wr_en = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        for (int i = 0; i < M; i++) begin
            e_dv[i] = 1'b0; e_dd[i] = '0; e_ack[i] = 1'b0; e_rd[i] = '0;
            e_wr[i] = 1'b0; e_addr[i] = '0; e_wd[i] = '0; e_own[i] = 0;
        end
        for (int i = 0; i < 4096; i++) begin
            v = DW'($urandom);
            ram[i] = v; mmem[i] = v;
        end
        ram[16'h010] = 16'h1F41; mmem[16'h010] = 16'h1F41;

        // Reset held 2 cycles with both requesters active.
        q.push_back('{1'b0, 12'h010, 16'h0000});
        tick(1'b0, 1'b1, 12'h3FF);
        tick(1'b0, 1'b1, 12'h3FF);
        chk_on = 1'b1;
        #2;
        chk("rst ram_addr", 32'(bus.ram_addr), 32'h0);
        chk("rst ram_wr_en", 32'(bus.ram_wr_en), 32'h0);
        chk("rst ram_wdata", 32'(bus.ram_wdata), 32'h0);
        chk("rst disp_valid", 32'(bus.disp_valid), 32'h0);
        chk("rst disp_data", 32'(bus.disp_data), 32'h0);
        chk("rst cpu_ack", 32'(bus.cpu_ack), 32'h0);
        chk("rst cpu_rdata", 32'(bus.cpu_rdata), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b0, 12'h000);
            #2;
            chk("post-rst cpu_ack", 32'(bus.cpu_ack), 32'h0);
            chk("post-rst disp_valid", 32'(bus.disp_valid), 32'h0);
        end

        // Single display fetch of 0x010.
        tick(1'b1, 1'b1, 12'h010);
        tick(1'b1, 1'b0, 12'h000);
        #2;
        chk("fetch ram_addr", 32'(bus.ram_addr), 32'h010);
        chk("fetch ram_wr_en", 32'(bus.ram_wr_en), 32'h0);
        tick(1'b1, 1'b0, 12'h000);
        #2;
        chk("fetch early valid", 32'(bus.disp_valid), 32'h0);
        tick(1'b1, 1'b0, 12'h000);
        #2;
        chk("fetch disp_valid", 32'(bus.disp_valid), 32'h1);
        chk("fetch disp_data", 32'(bus.disp_data), 32'h1F41);
        tick(1'b1, 1'b0, 12'h000);
        #2;
        chk("fetch valid drop", 32'(bus.disp_valid), 32'h0);

        // CPU write 0xBEEF to 0x123 then read it back.
        q.push_back('{1'b1, 12'h123, 16'hBEEF});
        q.push_back('{1'b0, 12'h123, 16'h0000});
        tick(1'b1, 1'b0, 12'h000);
        tick(1'b1, 1'b0, 12'h000);
        #2;
        chk("wr ram_wr_en", 32'(bus.ram_wr_en), 32'h1);
        chk("wr ram_addr", 32'(bus.ram_addr), 32'h123);
        chk("wr ram_wdata", 32'(bus.ram_wdata), 32'hBEEF);
        tick(1'b1, 1'b0, 12'h000);
        #2;
        chk("wr strobe one cycle", 32'(bus.ram_wr_en), 32'h0);
        tick(1'b1, 1'b0, 12'h000);
        #2;
        chk("wr cpu_ack", 32'(bus.cpu_ack), 32'h1);
        chk("wr cpu_rdata", 32'(bus.cpu_rdata), 32'h0);
        for (int k = 0; k < 5; k++) tick(1'b1, 1'b0, 12'h000);
        #2;
        chk("rd cpu_ack", 32'(bus.cpu_ack), 32'h1);
        chk("rd cpu_rdata", 32'(bus.cpu_rdata), 32'hBEEF);

        // Collision: CPU request rises with a 4-word display burst.
        tick(1'b1, 1'b0, 12'h000);
        q.push_back('{1'b0, 12'h200, 16'h0000});
        for (int k = 0; k < 4; k++) tick(1'b1, 1'b1, 12'(k));
        tick(1'b1, 1'b0, 12'h000);
        #2;
        chk("burst last disp addr", 32'(bus.ram_addr), 32'h003);
        tick(1'b1, 1'b0, 12'h000);
        #2;
        chk("collision cpu addr", 32'(bus.ram_addr), 32'h200);
        for (int k = 0; k < 4; k++) tick(1'b1, 1'b0, 12'h000);

        // Interleave: display every other cycle, continuous CPU reads.
        for (int k = 0; k < 40; k++) begin
            if (q.size() == 0) q.push_back('{1'b0, 12'($urandom), 16'($urandom)});
            tick(1'b1, (k % 2) == 0, 12'($urandom));
        end
        for (int k = 0; k < 12 && (m_active || q.size() > 0); k++) tick(1'b1, 1'b0, 12'h000);

        // Reset in the CPU write issue cycle.
        q.push_back('{1'b1, 12'h055, 16'hDEAD});
        tick(1'b0, 1'b0, 12'h000);
        for (int k = 0; k < 5; k++) begin
            tick(1'b1, 1'b0, 12'h000);
            #2;
            chk("abort no write", 32'(bus.ram_wr_en), 32'h0);
            chk("abort no ack", 32'(bus.cpu_ack), 32'h0);
        end

        // Random traffic with occasional resets over a small address window.
        for (int k = 0; k < 2000; k++) begin
            if (q.size() == 0 && $urandom_range(0, 2) == 0) begin
                d = 1'($urandom_range(0, 1));
                q.push_back('{d, 12'($urandom_range(0, 31)), 16'($urandom)});
            end
            tick($urandom_range(0, 199) != 0, 1'($urandom_range(0, 1)),
                 12'($urandom_range(0, 31)));
        end
        for (int k = 0; k < 8; k++) tick(1'b1, 1'b0, 12'h000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_mem_arbiter.md
# vga_mem_arbiter

Single-port video RAM arbiter that shares one synchronous RAM between the VGA scan-out fetch path and the CPU bus. Display fetches are hard real-time: they have absolute priority and a fixed latency. CPU accesses are serviced in any slot the display leaves free, with a one-cycle ack handshake. The block sits between the VGA timing/fetch logic and the frame/text buffer RAM.

## Interface
- ADDR_W, 12, RAM word-address width (4K words)
- DATA_W, 16, RAM word width (char + attribute in text mode)

- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- disp_req  in  1  display fetch request, single-cycle pulse per word
- disp_addr  in  ADDR_W  display fetch address, valid with disp_req
- disp_valid  out  1  pulses high for one cycle when disp_data is valid
- disp_data  out  DATA_W  fetched display word
- cpu_access  in  1  CPU request; held high until cpu_ack is seen
- cpu_wr_en  in  1  1 = write, 0 = read; stable while cpu_access is high
- cpu_addr  in  ADDR_W  CPU word address; stable while cpu_access is high
- cpu_wdata  in  DATA_W  CPU write data; stable while cpu_access is high
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data, valid with cpu_ack; 0 for writes
- ram_addr  out  ADDR_W  RAM address, registered
- ram_wr_en  out  1  RAM write strobe, registered
- ram_wdata  out  DATA_W  RAM write data, registered
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_addr is presented

## Operation
- Issue stage runs every cycle. disp_req has priority: if disp_req=1 in cycle N, the RAM port carries the display read (ram_wr_en=0, ram_addr=disp_addr) in cycle N+1.
- The display pipeline is 3 stages of valid bits plus the returned data. There is no display queue. Back-to-back disp_req every cycle is legal and fully pipelined.
- CPU FSM has four states: IDLE, RAM, DATA, ACK.
  - IDLE -> RAM when cpu_access=1 and disp_req=0. Address, write enable and write data are latched, then driven onto the RAM port in RAM.
  - IDLE stays in IDLE while disp_req=1. The CPU is starved for as long as disp_req stays high.
  - RAM -> DATA -> ACK unconditionally.
  - In ACK: cpu_ack=1, and cpu_rdata holds the captured ram_rdata (read) or 0 (write).
  - ACK -> IDLE.
- A display request arriving while the FSM is in RAM/DATA/ACK never collides. The CPU uses the port only in the RAM cycle, which was reserved when disp_req was 0 in the issue cycle.
- The requester must drive cpu_access low in the cycle after cpu_ack. A registered master satisfies this.
- When neither source owns the port: ram_wr_en=0, and ram_addr/ram_wdata hold their last value.
- Writes never go through the display path. The CPU is the only writer.

## Timing
- Reset (reset_n=0 at a clock edge):
  - FSM enters IDLE; all valid bits clear.
  - disp_valid, disp_data, cpu_ack, cpu_rdata, ram_addr, ram_wr_en and ram_wdata are all 0.
- Reset mid-operation: in-flight display and CPU transactions are discarded. No disp_valid or cpu_ack is produced for them, and no RAM write occurs after the reset edge.
- Display latency is fixed: disp_req in cycle N leads to ram_addr in N+1, ram_rdata in N+2, and disp_valid with disp_data in N+3.
- CPU latency: first issue cycle M (IDLE, cpu_access=1, disp_req=0) leads to the RAM cycle at M+1 and cpu_ack at M+3. Read and write latency are identical.
- Simultaneous disp_req and cpu_access in IDLE: the display wins and the CPU re-arbitrates next cycle.
- With disp_req alternating every other cycle, the CPU issues within 1 cycle of the gap.
- Address arithmetic wraps at 2^ADDR_W; the block does no bounds checking.

## Test plan
- Reset: hold reset_n=0 for 2 cycles with cpu_access=1 and disp_req=1 -> all outputs 0, and cpu_ack/disp_valid stay 0 for 3 cycles after release unless requests are re-presented.
- Display fetch: RAM preloaded with mem[0x010]=0x1F41; disp_req with disp_addr=0x010 at cycle 10 -> ram_addr=0x010 at 11, disp_valid=1 with disp_data=0x1F41 at 13 only.
- CPU write then read: write 0xBEEF to 0x123 -> ram_wr_en=1 with ram_addr=0x123 for exactly one cycle, cpu_ack 3 cycles after issue. Then read 0x123 -> cpu_rdata=0xBEEF with cpu_ack.
- Collision: cpu_access rises in the same cycle as a 4-cycle burst of disp_req (addrs 0x000-0x003) -> four disp_valid pulses at fixed latency, CPU RAM cycle immediately after the last display RAM cycle, no ram_wr_en overlap with any display read.
- Interleave: disp_req every other cycle plus continuous CPU reads of different addresses -> every display word returns at N+3 and every CPU ack carries the correct data.
- Reset mid-CPU-write: assert reset_n=0 in the cycle the FSM is in IDLE->RAM transition -> no ram_wr_en pulse and no cpu_ack is observed.
